// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB master bridge.
// Holds the transfer-phase state encoding, default parameter widths and
// the helper that sizes the slave-index address field.
package apb_pkg;

    // APB transfer phases; encodings match the legacy FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned APB_ADDR_W_DEF      = 32;
    localparam int unsigned APB_DATA_W_DEF      = 32;
    localparam int unsigned APB_NUM_SLV_DEF     = 4;
    localparam int unsigned APB_SLV_SEL_LSB_DEF = 12;
    localparam int unsigned APB_TIMEOUT_CYC_DEF = 16;

    // Width of the slave-index field; a single slave still uses one bit so
    // that addresses with that bit set are reported as decode errors.
    function automatic int unsigned slv_idx_w(input int unsigned num_slv);
        return (num_slv <= 1) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// apb_slave_decode: turns the slave-index address field into a one-hot
// select vector and flags indices that have no slave behind them.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLV = APB_NUM_SLV_DEF,
    parameter int unsigned IDX_W   = slv_idx_w(APB_NUM_SLV_DEF)
) (
    input  logic [IDX_W-1:0]   idx_field,
    output logic [NUM_SLV-1:0] sel,
    output logic               dec_err
);

    logic [31:0] idx_ext;

    // One-hot select for in-range indices; out-of-range gives no select.
    always_comb begin
        idx_ext = 32'(idx_field);
        sel     = '0;
        dec_err = (idx_ext >= NUM_SLV);
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            sel[i] = (idx_ext == i);
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: command/response to APB master.
// Accepts one command at a time in IDLE, runs SETUP then ACCESS (with
// pready wait states) and returns a single-cycle response pulse carrying
// read data and an error flag (slave error or decode error).
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase wait limit of
// TIMEOUT_CYC cycles that ends the transfer with an error response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W_DEF,
    parameter int unsigned DATA_W      = APB_DATA_W_DEF,
    parameter int unsigned NUM_SLV     = APB_NUM_SLV_DEF,
    parameter int unsigned SLV_SEL_LSB = APB_SLV_SEL_LSB_DEF,
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC_DEF
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [NUM_SLV-1:0] psel,
    output logic               penable,
    output logic               pwrite,
    output logic [ADDR_W-1:0]  paddr,
    output logic [DATA_W-1:0]  pwdata,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int unsigned IDX_W = slv_idx_w(NUM_SLV);

    apb_state_e state, state_nxt;

    logic               accept;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_err;
    logic               timeout;

    logic [NUM_SLV-1:0] psel_nxt;
    logic               penable_nxt;
    logic               pwrite_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [DATA_W-1:0]  pwdata_nxt;
    logic               rsp_valid_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;
    logic               rsp_err_nxt;

    // Ready only in IDLE and never while reset is asserted.
    assign cmd_ready = (state == IDLE) && preset;
    assign accept    = cmd_valid && cmd_ready;

    apb_slave_decode #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_decode (
        .idx_field (cmd_addr[SLV_SEL_LSB +: IDX_W]),
        .sel       (dec_sel),
        .dec_err   (dec_err)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the edge where the count reaches TIMEOUT_CYC; pready has priority.
    assign timeout = (state == ACCESS) && !pready &&
                     (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nxt     = state;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (accept) begin
                    paddr_nxt  = cmd_addr;
                    pwrite_nxt = cmd_write;
                    pwdata_nxt = cmd_write ? cmd_wdata : '0;
                    if (dec_err) begin
                        // No slave at this index: answer immediately, no bus cycle.
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end else begin
                        state_nxt   = SETUP;
                        psel_nxt    = dec_sel;
                        penable_nxt = 1'b0;
                    end
                end
            end

            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (pready) begin
                    state_nxt     = IDLE;
                    psel_nxt      = '0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr;
                    rsp_rdata_nxt = (!pwrite && !pslverr) ? prdata : '0;
                end else if (timeout) begin
                    state_nxt     = IDLE;
                    psel_nxt      = '0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                psel_nxt    = '0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // APB and response output registers.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for apb_master_bridge.
// Directed commands push their expected response; a monitor pops and
// compares on every rsp_valid. A behavioural slave supplies wait states.
module tb_apb_master_bridge;

    logic pclk = 1'b0;
    logic preset = 1'b0;
    always #5 pclk = ~pclk;

    // Main DUT, NUM_SLV = 4
    logic        cmd_valid, cmd_write, cmd_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    // Decode-error DUT, NUM_SLV = 3
    logic        c3_valid, c3_write, c3_ready;
    logic [31:0] c3_addr, c3_wdata;
    logic        r3_valid, r3_err;
    logic [31:0] r3_rdata;
    logic [2:0]  psel3;
    logic        penable3, pwrite3;
    logic [31:0] paddr3, pwdata3;
    logic [31:0] prdata3 = 32'h0;
    logic        pready3 = 1'b1;
    logic        pslverr3 = 1'b0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SEL_LSB(12), .TIMEOUT_CYC(16)
    ) u_dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_SEL_LSB(12), .TIMEOUT_CYC(16)
    ) u_dut3 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
        .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
        .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err),
        .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
        .pwdata(pwdata3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t        sbq[$];
    int unsigned accq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record the edge number of every accepted command.
    always @(negedge pclk) begin
        if (preset && cmd_valid && cmd_ready) accq.push_back(cyc + 1);
    end

    // Response monitor: pops the scoreboard on each rsp_valid.
    always @(negedge pclk) begin : rsp_mon
        exp_t        e;
        int unsigned a;
        if (preset && rsp_valid) begin
            if (sbq.size() == 0 || accq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                a = accq.pop_front();
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_latency", cyc - a, e.lat);
            end
        end
    end

    // Behavioural slave: pready after s_waits ACCESS cycles.
    int unsigned s_waits = 0;
    int unsigned s_cnt = 0;
    logic [31:0] s_rdata = '0;
    logic        s_err = 1'b0;
    logic        s_noise = 1'b0;
    logic        s_chk = 1'b0;
    logic [31:0] s_paddr = '0;

    always @(negedge pclk) begin
        if (preset && (|psel) && penable) begin
            if (s_chk) check("access_paddr_stable", paddr, s_paddr);
            if (s_cnt == s_waits) begin
                pready  = 1'b1;
                prdata  = s_rdata;
                pslverr = s_err;
            end else begin
                pready  = 1'b0;
                prdata  = 32'hBAD0_BAD0;
                pslverr = 1'b0;
                s_cnt++;
            end
        end else begin
            // Outside ACCESS these must be ignored; optionally drive them high.
            pready  = s_noise;
            pslverr = s_noise;
            prdata  = 32'h0BAD_0BAD;
            s_cnt   = 0;
        end
    end

    task automatic wait_accept(input string name, output int unsigned acc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            if (cmd_valid && cmd_ready) got = 1'b1;
        end
        acc = cyc + 1;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s: got no accept expected accept within 20 cycles", name);
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_rsp_done(input string name);
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge pclk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d pending responses expected 0", name, sbq.size());
        end
        sbq.delete();
        accq.delete();
        @(negedge pclk);
        check({name, "_idle_psel"}, {28'b0, psel}, 32'h0);
        check({name, "_idle_penable"}, {31'b0, penable}, 32'h0);
    endtask

    task automatic run_cmd(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_psel,
                           input int unsigned waits, input logic [31:0] rd, input logic serr,
                           input logic noise, input logic [31:0] exp_rdata,
                           input logic exp_err, input int unsigned exp_lat);
        exp_t        e;
        int unsigned acc;
        @(posedge pclk);
        #1;
        s_waits = waits;
        s_rdata = rd;
        s_err   = serr;
        s_noise = noise;
        s_paddr = addr;
        s_chk   = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sbq.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        wait_accept({name, "_accept"}, acc);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'h5555_5555;
        @(negedge pclk);
        check({name, "_setup_psel"}, {28'b0, psel}, {28'b0, exp_psel});
        check({name, "_setup_penable"}, {31'b0, penable}, 32'h0);
        check({name, "_paddr"}, paddr, addr);
        check({name, "_pwrite"}, {31'b0, pwrite}, {31'b0, wr});
        check({name, "_pwdata"}, pwdata, wr ? wdata : 32'h0);
        @(negedge pclk);
        check({name, "_access_penable"}, {31'b0, penable}, 32'h1);
        check({name, "_access_psel"}, {28'b0, psel}, {28'b0, exp_psel});
        wait_rsp_done(name);
        s_chk   = 1'b0;
        s_noise = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_psel"}, {28'b0, psel}, 32'h0);
        check({name, "_penable"}, {31'b0, penable}, 32'h0);
        check({name, "_pwrite"}, {31'b0, pwrite}, 32'h0);
        check({name, "_paddr"}, paddr, 32'h0);
        check({name, "_pwdata"}, pwdata, 32'h0);
        check({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        check({name, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({name, "_rsp_err"}, {31'b0, rsp_err}, 32'h0);
        check({name, "_cmd_ready"}, {31'b0, cmd_ready}, 32'h0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t        e1, e2;
        int unsigned a1, a2;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        c3_valid = 1'b0; c3_write = 1'b0; c3_addr = '0; c3_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;

        // Reset state
        repeat (3) @(negedge pclk);
        check_all_zero("reset");
        @(posedge pclk);
        #1;
        preset = 1'b1;
        @(negedge pclk);
        check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        // Zero-wait write, slave 2
        run_cmd("wr0", 1'b1, 32'h0000_2010, 32'hA5A5_0001, 4'b0100, 0,
                32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        // Read with 3 wait states, pready/pslverr toggled outside ACCESS
        run_cmd("rd3w", 1'b0, 32'h0000_1004, 32'h1357_9BDF, 4'b0010, 3,
                32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5);
        // Slave error on read
        run_cmd("rderr", 1'b0, 32'h0000_0008, 32'h0, 4'b0001, 0,
                32'h0000_1234, 1'b1, 1'b0, 32'h0, 1'b1, 2);
        // Slave error on write with one wait state, highest slave
        run_cmd("wrerr", 1'b1, 32'h0000_3ABC, 32'h0BAD_F00D, 4'b1000, 1,
                32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 3);
        check("idle_hold_paddr", paddr, 32'h0000_3ABC);
        check("idle_hold_pwdata", pwdata, 32'h0BAD_F00D);

        // Back-to-back: cmd_valid held across two commands
        @(posedge pclk);
        #1;
        s_waits = 0; s_rdata = 32'hCAFE_F00D; s_err = 1'b0; s_chk = 1'b0;
        e1.rdata = 32'h0;          e1.err = 1'b0; e1.lat = 2;
        e2.rdata = 32'hCAFE_F00D;  e2.err = 1'b0; e2.lat = 2;
        sbq.push_back(e1);
        sbq.push_back(e2);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0014; cmd_wdata = 32'h1111_2222;
        wait_accept("b2b_accept1", a1);
        cmd_write = 1'b0; cmd_addr = 32'h0000_2020; cmd_wdata = 32'h3333_4444;
        @(negedge pclk);
        check("b2b_setup_ready", {31'b0, cmd_ready}, 32'h0);
        check("b2b_setup_psel", {28'b0, psel}, 32'h1);
        @(negedge pclk);
        check("b2b_access_ready", {31'b0, cmd_ready}, 32'h0);
        @(negedge pclk);
        check("b2b_gap_psel", {28'b0, psel}, 32'h0);
        check("b2b_gap_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("b2b_gap_ready", {31'b0, cmd_ready}, 32'h1);
        a2 = cyc + 1;
        check("b2b_accept_spacing", a2 - a1, 3);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("b2b_setup2_psel", {28'b0, psel}, 32'h4);
        check("b2b_setup2_pwdata", pwdata, 32'h0);
        wait_rsp_done("b2b");

`ifdef APB_TIMEOUT_EN
        // Slave never ready: 16 ACCESS cycles then error
        run_cmd("tmo", 1'b0, 32'h0000_1100, 32'h0, 4'b0010, 1000,
                32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b1, 17);
`endif

        // Decode error on the three-slave instance
        @(posedge pclk);
        #1;
        c3_valid = 1'b1; c3_write = 1'b1; c3_addr = 32'h0000_3000; c3_wdata = 32'hFFFF_FFFF;
        @(negedge pclk);
        check("dec_ready", {31'b0, c3_ready}, 32'h1);
        @(posedge pclk);
        #1;
        c3_valid = 1'b0;
        @(negedge pclk);
        check("dec_rsp_valid", {31'b0, r3_valid}, 32'h1);
        check("dec_rsp_err", {31'b0, r3_err}, 32'h1);
        check("dec_rsp_rdata", r3_rdata, 32'h0);
        check("dec_psel", {29'b0, psel3}, 32'h0);
        check("dec_penable", {31'b0, penable3}, 32'h0);
        @(negedge pclk);
        check("dec_rsp_pulse", {31'b0, r3_valid}, 32'h0);
        check("dec_psel_after", {29'b0, psel3}, 32'h0);
        @(posedge pclk);
        #1;
        c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 32'h0000_2000;
        @(posedge pclk);
        #1;
        c3_valid = 1'b0;
        @(negedge pclk);
        check("dec_valid_psel", {29'b0, psel3}, 32'h4);
        repeat (3) @(negedge pclk);

        // Reset mid-ACCESS: outputs clear at once, no response
        @(posedge pclk);
        #1;
        s_waits = 1000; s_chk = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_3008; cmd_wdata = 32'h0000_0077;
        wait_accept("rst_accept", a1);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_pre_penable", {31'b0, penable}, 32'h1);
        #2;
        preset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        accq.delete();
        repeat (3) @(negedge pclk);
        @(posedge pclk);
        #1;
        preset = 1'b1;
        repeat (5) @(negedge pclk);
        check("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        check("rst_idle_ready", {31'b0, cmd_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
